// File: rtl/mac_pkg.sv
// mac_pkg: definitions shared by the sign-magnitude MAC and its downstream
// requantisation stage.
//   - default datapath widths (MAC result, activation, shift amount)
//   - 2-bit FSM state encoding (IDLE=0, ROUND=1, CLAMP=2, OUT=3)
package mac_pkg;

   localparam int IN_BITWIDTH_DEF    = 19;
   localparam int OUT_BITWIDTH_DEF   = 8;
   localparam int SHIFT_BITWIDTH_DEF = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ROUND = 2'd1;
   localparam logic [1:0] ST_CLAMP = 2'd2;
   localparam logic [1:0] ST_OUT   = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_ROUND = ST_ROUND,
      S_CLAMP = ST_CLAMP,
      S_OUT   = ST_OUT
   } state_t;

endpackage

// File: rtl/sm_requant.sv
// sm_requant: requantises one sign-magnitude MAC result into a narrower
// sign-magnitude activation. Rounding right-shift (round-half-up on the
// magnitude), optional ReLU, saturation, then a valid/ready output.
// One result per 4 cycles (IDLE -> ROUND -> CLAMP -> OUT).
//
// Ports:
//   clk, rstn       clock, asynchronous active-low reset
//   in_valid        one-cycle capture strobe (MAC done)
//   in_data         sign-magnitude MAC result, MSB = sign
//   shift           right-shift amount, sampled on capture
//   relu_en         clamp negative results to zero, sampled on capture
//   out_valid       result available
//   out_ready       consumer accepts the result
//   out_data        sign-magnitude result, MSB = sign
//   sat_flag        current out_data was saturated
//   sat_count       saturated-result counter, sticks at 0xFFFF
//   overrun         sticky, in_valid seen while not IDLE
//   busy            FSM not IDLE
module sm_requant
   import mac_pkg::*;
#(
   parameter int IN_BITWIDTH    = IN_BITWIDTH_DEF,
   parameter int OUT_BITWIDTH   = OUT_BITWIDTH_DEF,
   parameter int SHIFT_BITWIDTH = SHIFT_BITWIDTH_DEF
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      in_valid,
   input  logic [IN_BITWIDTH-1:0]    in_data,
   input  logic [SHIFT_BITWIDTH-1:0] shift,
   input  logic                      relu_en,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [OUT_BITWIDTH-1:0]   out_data,
   output logic                      sat_flag,
   output logic [15:0]               sat_count,
   output logic                      overrun,
   output logic                      busy
);

   localparam logic [IN_BITWIDTH-1:0] MAG_MAX =
      IN_BITWIDTH'((1 << (OUT_BITWIDTH-1)) - 1);

   // Rounding right shift. The sum is one bit wider than the magnitude so
   // the rounding carry out of the top magnitude bit is kept.
   function automatic logic [IN_BITWIDTH-1:0] round_shift(
      input logic [IN_BITWIDTH-2:0]    m,
      input logic [SHIFT_BITWIDTH-1:0] s
   );
      logic [IN_BITWIDTH-1:0] bias;
      logic [IN_BITWIDTH-1:0] sum;
      bias = '0;
      if (s != '0)
         bias = {{(IN_BITWIDTH-1){1'b0}}, 1'b1} << (s - 1'b1);
      sum = {1'b0, m} + bias;
      return sum >> s;
   endfunction

   // Returns {sat, out_data}. Priority: ReLU, saturation, zero (never a
   // negative zero), pass-through.
   function automatic logic [OUT_BITWIDTH:0] clamp_sat(
      input logic                   sgn,
      input logic                   relu,
      input logic [IN_BITWIDTH-1:0] m
   );
      if (relu && sgn)
         return '0;
      else if (m > MAG_MAX)
         return {1'b1, sgn, {(OUT_BITWIDTH-1){1'b1}}};
      else if (m == '0)
         return '0;
      else
         return {1'b0, sgn, m[OUT_BITWIDTH-2:0]};
   endfunction

   state_t state, state_nxt;

   logic                      sign_p0;
   logic [IN_BITWIDTH-2:0]    mag_p0;
   logic [SHIFT_BITWIDTH-1:0] shift_p0;
   logic                      relu_p0;
   logic [IN_BITWIDTH-1:0]    rnd_p1;
   logic [OUT_BITWIDTH:0]     clamp_res;

   assign busy      = (state != S_IDLE);
   assign clamp_res = clamp_sat(sign_p0, relu_p0, rnd_p1);

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (in_valid) state_nxt = S_ROUND;
         S_ROUND: state_nxt = S_CLAMP;
         S_CLAMP: state_nxt = S_OUT;
         S_OUT:   if (out_valid && out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Capture stage (p0) and rounding stage (p1); no reset needed, these
   // are only consumed after the FSM has walked through them.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && in_valid) begin
         sign_p0  <= in_data[IN_BITWIDTH-1];
         mag_p0   <= in_data[IN_BITWIDTH-2:0];
         shift_p0 <= shift;
         relu_p0  <= relu_en;
      end
      if (state == S_ROUND)
         rnd_p1 <= round_shift(mag_p0, shift_p0);
   end

   // Output stage and control.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= S_IDLE;
         out_valid <= 1'b0;
         out_data  <= '0;
         sat_flag  <= 1'b0;
         sat_count <= '0;
         overrun   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (in_valid && state != S_IDLE)
            overrun <= 1'b1;
         if (state == S_CLAMP) begin
            out_valid <= 1'b1;
            out_data  <= clamp_res[OUT_BITWIDTH-1:0];
            sat_flag  <= clamp_res[OUT_BITWIDTH];
            if (clamp_res[OUT_BITWIDTH] && sat_count != 16'hFFFF)
               sat_count <= sat_count + 16'd1;
         end
         if (state == S_OUT && out_valid && out_ready)
            out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sm_requant.sv
module tb_sm_requant;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        in_valid = 1'b0;
   logic [18:0] in_data = '0;
   logic [3:0]  shift = '0;
   logic        relu_en = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_data;
   logic        sat_flag;
   logic [15:0] sat_count;
   logic        overrun;
   logic        busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sm_requant dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
      .shift(shift), .relu_en(relu_en), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .sat_flag(sat_flag),
      .sat_count(sat_count), .overrun(overrun), .busy(busy)
   );

   typedef struct {
      logic [18:0] din;
      logic [3:0]  sh;
      logic        relu;
      logic [7:0]  exp_data;
      logic        exp_sat;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one capture; out_ready stays high. Checks the full 4-cycle cadence.
   task automatic run_one(input logic [18:0] d, input logic [3:0] s, input logic r,
                          input logic [7:0] ed, input logic es, input logic [15:0] ec,
                          input string tag);
      @(negedge clk);
      in_valid = 1'b1; in_data = d; shift = s; relu_en = r;
      @(posedge clk);                      // edge k
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, " busy_k"}, {31'd0, busy}, 32'd1);
      check({tag, " vld_k"}, {31'd0, out_valid}, 32'd0);
      @(posedge clk);                      // edge k+1
      @(negedge clk);
      check({tag, " vld_k1"}, {31'd0, out_valid}, 32'd0);
      @(posedge clk);                      // edge k+2
      @(negedge clk);
      check({tag, " vld_k2"}, {31'd0, out_valid}, 32'd1);
      check({tag, " data"}, {24'd0, out_data}, {24'd0, ed});
      check({tag, " sat"}, {31'd0, sat_flag}, {31'd0, es});
      check({tag, " cnt"}, {16'd0, sat_count}, {16'd0, ec});
      @(posedge clk);                      // edge k+3
      @(negedge clk);
      check({tag, " vld_k3"}, {31'd0, out_valid}, 32'd0);
      check({tag, " idle_k3"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running, expected done");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{19'h003E8, 4'd3,  1'b0, 8'h7D, 1'b0, 16'd0};
      vecs[1]  = '{19'h403E8, 4'd3,  1'b0, 8'hFD, 1'b0, 16'd0};
      vecs[2]  = '{19'h403E8, 4'd3,  1'b1, 8'h00, 1'b0, 16'd0};
      vecs[3]  = '{19'h01388, 4'd3,  1'b0, 8'h7F, 1'b1, 16'd1};
      vecs[4]  = '{19'h41388, 4'd3,  1'b0, 8'hFF, 1'b1, 16'd2};
      vecs[5]  = '{19'h41388, 4'd3,  1'b1, 8'h00, 1'b0, 16'd2};
      vecs[6]  = '{19'h0000C, 4'd3,  1'b0, 8'h02, 1'b0, 16'd2};
      vecs[7]  = '{19'h0000B, 4'd3,  1'b0, 8'h01, 1'b0, 16'd2};
      vecs[8]  = '{19'h40003, 4'd3,  1'b0, 8'h00, 1'b0, 16'd2};
      vecs[9]  = '{19'h00064, 4'd0,  1'b0, 8'h64, 1'b0, 16'd2};
      vecs[10] = '{19'h0007F, 4'd0,  1'b0, 8'h7F, 1'b0, 16'd2};
      vecs[11] = '{19'h00080, 4'd0,  1'b0, 8'h7F, 1'b1, 16'd3};
      vecs[12] = '{19'h3FFFF, 4'd15, 1'b0, 8'h08, 1'b0, 16'd3};
      vecs[13] = '{19'h40005, 4'd1,  1'b0, 8'h83, 1'b0, 16'd3};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst out_valid", {31'd0, out_valid}, 32'd0);
      check("rst out_data", {24'd0, out_data}, 32'd0);
      check("rst sat_flag", {31'd0, sat_flag}, 32'd0);
      check("rst sat_count", {16'd0, sat_count}, 32'd0);
      check("rst overrun", {31'd0, overrun}, 32'd0);
      check("rst busy", {31'd0, busy}, 32'd0);
      rstn = 1'b1;

      // Table-driven vectors
      for (int i = 0; i < 14; i++)
         run_one(vecs[i].din, vecs[i].sh, vecs[i].relu, vecs[i].exp_data,
                 vecs[i].exp_sat, vecs[i].exp_cnt, $sformatf("vec%0d", i));
      check("no overrun", {31'd0, overrun}, 32'd0);

      // Backpressure with an overrun pulse during the hold
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 19'h003E8; shift = 4'd3; relu_en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("bp vld", {31'd0, out_valid}, 32'd1);
      check("bp data", {24'd0, out_data}, 32'h7D);
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin
            in_valid = 1'b1; in_data = 19'h00064; shift = 4'd0;
         end
         @(posedge clk);
         @(negedge clk);
         in_valid = 1'b0;
         check($sformatf("bp hold data c%0d", c), {24'd0, out_data}, 32'h7D);
         check($sformatf("bp hold vld c%0d", c), {31'd0, out_valid}, 32'd1);
         check($sformatf("bp hold busy c%0d", c), {31'd0, busy}, 32'd1);
      end
      check("bp overrun", {31'd0, overrun}, 32'd1);
      check("bp sat", {31'd0, sat_flag}, 32'd0);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp release vld", {31'd0, out_valid}, 32'd0);
      check("bp release busy", {31'd0, busy}, 32'd0);
      check("bp overrun sticky", {31'd0, overrun}, 32'd1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("bp no 2nd result", {31'd0, out_valid}, 32'd0);

      // Reset asserted during ROUND
      @(negedge clk);
      in_valid = 1'b1; in_data = 19'h01388; shift = 4'd3;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      rstn = 1'b0;
      #1;
      check("mid rst busy", {31'd0, busy}, 32'd0);
      check("mid rst vld", {31'd0, out_valid}, 32'd0);
      check("mid rst overrun", {31'd0, overrun}, 32'd0);
      check("mid rst cnt", {16'd0, sat_count}, 32'd0);
      check("mid rst data", {24'd0, out_data}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("abandoned result", {31'd0, out_valid}, 32'd0);
      run_one(19'h00008, 4'd1, 1'b0, 8'h04, 1'b0, 16'd0, "post rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
